// File: rtl/column_approx_divider.sv
// Sequential restoring divider with column truncation of the dividend.
// Zeroes the THETA low dividend columns, then produces one quotient bit per
// cycle, MSB first. Valid/ready handshakes on both the input and output side.
module column_approx_divider #(
  parameter int LENGTH = 8,
  parameter int THETA  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LENGTH-1:0]   dividend,
  input  logic [LENGTH-1:0]     divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LENGTH-1:0]     quotient,
  output logic [LENGTH-1:0]     remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [2*LENGTH-1:0] dt_in;
  logic [LENGTH-1:0]   pr;
  logic [LENGTH-1:0]   low;
  logic [LENGTH-1:0]   dvs;
  logic [LENGTH-1:0]   q_work;
  logic [CW-1:0]       cnt;
  logic [LENGTH:0]     trial;
  logic                fits;
  logic [LENGTH-1:0]   pr_next;

  // Truncated dividend: the THETA least-significant columns read as zero.
  always_comb begin
    dt_in = '0;
    for (int i = 0; i < 2*LENGTH; i++) begin
      dt_in[i] = (i < THETA) ? 1'b0 : dividend[i];
    end
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    trial   = {pr, low[LENGTH-1]};
    fits    = (trial >= {1'b0, dvs});
    pr_next = fits ? LENGTH'(trial - {1'b0, dvs}) : trial[LENGTH-1:0];
  end

  // Control FSM and datapath registers; result outputs only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      pr          <= '0;
      low         <= '0;
      dvs         <= '0;
      q_work      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dt_in[LENGTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dt_in[2*LENGTH-1:LENGTH] >= divisor) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              overflow    <= 1'b1;
              div_by_zero <= 1'b0;
            end else begin
              state  <= BUSY;
              pr     <= dt_in[2*LENGTH-1:LENGTH];
              low    <= dt_in[LENGTH-1:0];
              dvs    <= divisor;
              q_work <= '0;
              cnt    <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(LENGTH)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_work;
            remainder   <= pr;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end else begin
            pr     <= pr_next;
            low    <= low << 1;
            q_work <= LENGTH'({q_work, fits});
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
